// File: rtl/tdm_pkg.sv
// rtl/tdm_pkg.sv - shared types and constants for the TDM link blocks
//
// Contents:
//   tdm_state_e : framer state, HUNT (searching for fsync) / LOCK (framed)
//   SLOTS_DATA  : data slots per frame
//   SLOT_W      : width of a slot index
//   frame_len() : slots per frame, one extra parity slot when TDM_PARITY_EN is defined
//   FRAME_N     : frame_len() evaluated for this build
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } tdm_state_e;

    localparam int SLOTS_DATA = 4;
    localparam int SLOT_W     = 3;

    function automatic int frame_len();
`ifdef TDM_PARITY_EN
        return SLOTS_DATA + 1;
`else
        return SLOTS_DATA;
`endif
    endfunction

    localparam int FRAME_N = frame_len();

endpackage

// File: rtl/tdm_slot_ctr.sv
// rtl/tdm_slot_ctr.sv - modulo-N slot counter with load-to-1 and clear
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force slot to 0 (highest priority)
//   load1      : force slot to 1 (the slot-0 sample has just been taken)
//   inc        : advance slot, wrapping from N-1 to 0
//   slot       : current slot index
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    localparam logic [SLOT_W-1:0] LAST = SLOT_W'(N - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (clear) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= (slot == LAST) ? '0 : slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/demux1to4_tdm.sv
// rtl/demux1to4_tdm.sv - four-channel TDM demultiplexer with frame-sync tracking
//
// Optional feature macro: TDM_PARITY_EN (adds a fifth, even-parity slot and parity_err).
//
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   din [W]        : serial sample for the current slot
//   fsync          : high when din carries slot 0
//   y0..y3 [W]     : channel outputs, updated together once per good frame
//   frame_valid    : one-cycle pulse when y0..y3 update
//   locked         : high while framed
//   slot [3]       : slot index expected for the next din sample
//   sync_err       : one-cycle pulse on fsync/slot disagreement
//   parity_err     : one-cycle pulse on a bad parity word (TDM_PARITY_EN only)
module demux1to4_tdm
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              fsync,
    output logic [W-1:0]      y0,
    output logic [W-1:0]      y1,
    output logic [W-1:0]      y2,
    output logic [W-1:0]      y3,
    output logic              frame_valid,
    output logic              locked,
    output logic [SLOT_W-1:0] slot,
    output logic              sync_err
`ifdef TDM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    // Without parity the slot-3 sample goes straight to y3, so only slots
    // 0..2 need holding; with parity slot 3 must wait for the check.
    localparam int                SHADOW_N  = FRAME_N - 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(FRAME_N - 1);

    tdm_state_e            state;
    tdm_state_e            state_nxt;
    logic                  ctr_clr;
    logic                  ctr_load1;
    logic                  ctr_inc;
    logic [SHADOW_N-1:0]   shadow_we;
    logic                  y_load;
    logic                  sync_err_nxt;
    logic [W-1:0]          shadow [SHADOW_N];
    logic [W-1:0]          y3_src;

`ifdef TDM_PARITY_EN
    logic [W-1:0]          par_calc;
    logic                  parity_err_nxt;

    assign par_calc = shadow[0] ^ shadow[1] ^ shadow[2] ^ shadow[3];
    assign y3_src   = shadow[3];
`else
    assign y3_src   = din;
`endif

    tdm_slot_ctr #(
        .N (FRAME_N)
    ) u_slot_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ctr_clr),
        .load1 (ctr_load1),
        .inc   (ctr_inc),
        .slot  (slot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        ctr_clr      = 1'b0;
        ctr_load1    = 1'b0;
        ctr_inc      = 1'b0;
        shadow_we    = '0;
        y_load       = 1'b0;
        sync_err_nxt = 1'b0;
`ifdef TDM_PARITY_EN
        parity_err_nxt = 1'b0;
`endif
        case (state)
            HUNT: begin
                if (fsync) begin
                    state_nxt    = LOCK;
                    ctr_load1    = 1'b1;
                    shadow_we[0] = 1'b1;
                end
            end
            LOCK: begin
                if (fsync) begin
                    // fsync always restarts the frame; off slot 0 the partial
                    // frame is abandoned and its shadows get overwritten.
                    ctr_load1    = 1'b1;
                    shadow_we[0] = 1'b1;
                    sync_err_nxt = (slot != '0);
                end else if (slot == '0) begin
                    state_nxt    = HUNT;
                    ctr_clr      = 1'b1;
                    sync_err_nxt = 1'b1;
                end else if (slot == LAST_SLOT) begin
                    ctr_inc = 1'b1;
`ifdef TDM_PARITY_EN
                    if (din == par_calc) begin
                        y_load = 1'b1;
                    end else begin
                        parity_err_nxt = 1'b1;
                    end
`else
                    y_load = 1'b1;
`endif
                end else begin
                    ctr_inc = 1'b1;
                    for (int i = 1; i < SHADOW_N; i++) begin
                        if (slot == SLOT_W'(i)) begin
                            shadow_we[i] = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_nxt = HUNT;
                ctr_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SHADOW_N; i++) begin
                shadow[i] <= '0;
            end
            y0          <= '0;
            y1          <= '0;
            y2          <= '0;
            y3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < SHADOW_N; i++) begin
                if (shadow_we[i]) begin
                    shadow[i] <= din;
                end
            end
            if (y_load) begin
                y0 <= shadow[0];
                y1 <= shadow[1];
                y2 <= shadow[2];
                y3 <= y3_src;
            end
            frame_valid <= y_load;
            sync_err    <= sync_err_nxt;
`ifdef TDM_PARITY_EN
            parity_err  <= parity_err_nxt;
`endif
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: doc/demux1to4_tdm.md
# demux1to4_tdm

Time-division demultiplexer: the receiving end of a four-channel TDM link whose transmitter is the team's 4-to-1 mux driven by a free-running select counter. It hunts for the frame-sync marker and tracks the slot position with an internal counter. It captures one sample per clock into a per-channel shadow register and presents all four channels as registered outputs, updated atomically once per complete frame.

## Interface
- W, default 1: width of each slot sample in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  serial TDM sample for the current slot.
- fsync  input  1  high in the cycle din carries slot 0.
- y0, y1, y2, y3  output  W each  registered channel outputs.
- frame_valid  output  1  one-cycle pulse when y0..y3 update.
- locked  output  1  high while framed (state LOCK).
- slot  output  3  slot index expected for the next din sample.
  - Slot-to-channel mapping matches the mux select pair {s0,s1}: 0→i0, 1→i1, 2→i2, 3→i3.
- sync_err  output  1  one-cycle pulse on an fsync/slot mismatch.
- parity_err  output  1  one-cycle pulse on a parity mismatch; present only with TDM_PARITY_EN.

## Operation
- Frame length N = 4 slots; N = 5 with TDM_PARITY_EN.
- States:
  - HUNT (reset state): ignore din until fsync = 1.
  - LOCK: framed.
- HUNT, fsync = 1: shadow0 <= din; slot <= 1; go to LOCK.
- LOCK, slot k in 1..3, fsync = 0: shadow[k] <= din; slot <= k+1, wrapping modulo N.
- Frame completion:
  - Completing slot is slot 3, or slot 4 with parity enabled.
  - On that edge: y0..y3 <= shadow0..shadow2 plus the slot-3 sample; frame_valid <= 1; slot <= 0.
- LOCK, slot = 0:
  - fsync = 1: normal; capture shadow0; slot <= 1.
  - fsync = 0: lost sync. Go to HUNT, discard partial frame, slot <= 0, sync_err pulse. y0..y3 hold their values.
- LOCK, fsync = 1 with slot ≠ 0: early sync.
  - Discard the partial frame.
  - Treat the sample as slot 0: shadow0 <= din; slot <= 1.
  - Stay in LOCK; sync_err pulse.
  - No frame_valid for the discarded frame.
- y0..y3 change only on a frame_valid edge. Partial frames never reach the outputs.

## Timing
- Reset values: y0..y3 = 0, frame_valid = 0, locked = 0, slot = 0, sync_err = 0, parity_err = 0, state = HUNT, shadows = 0.
- Reset is asynchronous mid-frame and discards the partial frame.
- Latency: y0..y3 and frame_valid become visible in the cycle after the completing slot's sample edge.
- frame_valid rate at steady state: one pulse per N cycles, never back-to-back.
- locked rises the cycle after the first accepted fsync. It falls the cycle after a lost-sync detection.
- All outputs are registered; no combinational path from din or fsync to any output.

## Configuration
- Macro TDM_PARITY_EN:
  - Defined: N = 5. Slot 4 carries the even parity word, the bitwise XOR of slots 0..3.
    - On the slot-4 edge, if din ≠ XOR of the four samples: y0..y3 hold, frame_valid stays 0, parity_err pulses one cycle.
    - Otherwise the frame completes normally.
    - slot reaches 4.
  - Undefined: N = 4. The parity_err port and parity logic are absent. slot never exceeds 3.

## Structure
- Shared package tdm_pkg contains:
  - State enum {HUNT, LOCK}.
  - Constants SLOTS_DATA = 4 and SLOT_W = 3.
  - Function computing N from TDM_PARITY_EN.
- One natural sub-module: tdm_slot_ctr, the modulo-N slot counter with sync-load-to-1 and clear inputs. It is shared with the future TDM transmitter.

## Test plan
- Reset, then fsync with din = 1,2,3,4 (W = 4):
  - Cycle after sample 4: y0=1, y1=2, y2=3, y3=4, frame_valid = 1 for exactly one cycle.
  - locked = 1 from the cycle after fsync.
- Three back-to-back frames A..D, 5..8, 9..C: frame_valid pulses every 4 cycles. Outputs step A,B,C,D → 5,6,7,8 → 9,A,B,C.
- fsync reasserted at slot 2 mid-frame:
  - sync_err pulses, old y values hold, locked stays 1.
  - The next four samples 7,7,7,7 yield y = 7,7,7,7.
- fsync absent at slot 0 after a good frame: sync_err pulse, locked → 0, slot = 0, y unchanged. Returns to LOCK on the next fsync.
- rst_n asserted after slot 2 of a frame: all outputs are 0 immediately. No frame_valid after release until a full new frame completes.
- TDM_PARITY_EN, samples 1,2,4,8:
  - Parity word F: frame completes.
  - Parity word E: parity_err pulses, y holds previous values, no frame_valid.
